// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM arbiter.
// Imported by arb_rr_pick and avalon_master_arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int REQ_INSTR = 0;
  localparam int REQ_EXT   = 1;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

  localparam int ARB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way winner select: round-robin on last_grant, or data wins
// outright when DATA_PRIORITY is set. Output is one-hot or zero.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] winner
);

  logic ext_win;

  // on a tie the requester that did not go last wins
  assign ext_win = valid[REQ_EXT] &&
                   ((DATA_PRIORITY != 0) ||
                    !valid[REQ_INSTR] ||
                    !last_grant);

  always_comb begin
    winner = 2'b00;
    if (ext_win)
      winner[REQ_EXT] = 1'b1;
    else if (valid[REQ_INSTR])
      winner[REQ_INSTR] = 1'b1;
  end

endmodule

// File: rtl/avalon_master_arbiter.sv
// Shares one Avalon-MM master between fetch (req0) and data (req1).
// Optional macro ARB_TIMEOUT_EN adds a WAIT timeout with sticky err.
module avalon_master_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DATA_PRIORITY = 0,
  parameter int TIMEOUT       = ARB_TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             req0_valid,
  input  logic             req0_rnw,
  input  logic [WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             req0_done,
  output logic [WIDTH-1:0] req0_rdata,
  input  logic             req1_valid,
  input  logic             req1_rnw,
  input  logic [WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req1_done,
  output logic [WIDTH-1:0] req1_rdata,
  output logic             m_start,
  output logic             m_rnw,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic             m_done,
  input  logic [WIDTH-1:0] m_rdata,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             err
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             last_grant;
  logic [1:0]       pick;
  logic [WIDTH-1:0] rdata_q;
  logic             timed_out;

  arb_rr_pick #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_pick (
    .valid     ({req1_valid, req0_valid}),
    .last_grant(last_grant),
    .winner    (pick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (|pick) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (m_done || timed_out)
               state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_start    = (state == ISSUE);
    busy       = (state != IDLE);
    req0_done  = (state == RESP) && grant[REQ_INSTR];
    req1_done  = (state == RESP) && grant[REQ_EXT];
    req0_rdata = req0_done ? rdata_q : '0;
    req1_rdata = req1_done ? rdata_q : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant      <= '0;
      last_grant <= 1'b1;
      m_rnw      <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rdata_q    <= '0;
    end else begin
      unique case (state)
        IDLE: if (|pick) begin
          grant   <= pick;
          m_rnw   <= pick[REQ_EXT] ? req1_rnw : req0_rnw;
          m_addr  <= pick[REQ_EXT] ? req1_addr : req0_addr;
          m_wdata <= pick[REQ_EXT] ? req1_wdata : req0_wdata;
        end
        WAIT: begin
          if (m_done)
            rdata_q <= m_rdata;
          else if (timed_out)
            rdata_q <= WIDTH'(ARB_ERR_DATA);
        end
        RESP: begin
          last_grant <= grant[REQ_EXT];
          grant      <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // fires on the TIMEOUT-th WAIT cycle; a real m_done still wins
  assign timed_out = (state == WAIT) && !m_done &&
                     (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      else               wait_cnt <= '0;
      if (timed_out) err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Random traffic against two arbiters (round-robin and data-priority),
// checked by a transaction-level model of requesters and master.
module tb_avalon_master_arbiter;

  localparam int W  = 32;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [1:0]   vld  [2];
  logic [1:0]   rnw  [2];
  logic [W-1:0] addr [2][2];
  logic [W-1:0] wdat [2][2];
  logic         md   [2];
  logic [W-1:0] mrd  [2];

  wire          d0   [2];
  wire          d1   [2];
  wire  [W-1:0] r0   [2];
  wire  [W-1:0] r1   [2];
  wire          ms   [2];
  wire          mrnw [2];
  wire  [W-1:0] ma   [2];
  wire  [W-1:0] mw   [2];
  wire  [1:0]   gr   [2];
  wire          bs   [2];
  wire          er   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    avalon_master_arbiter #(
      .WIDTH        (W),
      .DATA_PRIORITY(g),
      .TIMEOUT      (TO)
    ) u_dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .req0_valid(vld[g][0]),
      .req0_rnw  (rnw[g][0]),
      .req0_addr (addr[g][0]),
      .req0_wdata(wdat[g][0]),
      .req0_done (d0[g]),
      .req0_rdata(r0[g]),
      .req1_valid(vld[g][1]),
      .req1_rnw  (rnw[g][1]),
      .req1_addr (addr[g][1]),
      .req1_wdata(wdat[g][1]),
      .req1_done (d1[g]),
      .req1_rdata(r1[g]),
      .m_start   (ms[g]),
      .m_rnw     (mrnw[g]),
      .m_addr    (ma[g]),
      .m_wdata   (mw[g]),
      .m_done    (md[g]),
      .m_rdata   (mrd[g]),
      .grant     (gr[g]),
      .busy      (bs[g]),
      .err       (er[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // transaction-level model state, one slot per DUT
  int           last    [2];
  bit           infl    [2];
  bit           sdue    [2];
  logic [1:0]   ddue    [2];
  int           who     [2];
  logic         crnw    [2];
  logic [W-1:0] caddr   [2];
  logic [W-1:0] cwd     [2];
  logic [W-1:0] exp_rd  [2];
  bit           mact    [2];
  int           mcnt    [2];
  int           wn      [2];
  bit           err_exp [2];
  bit           hold = 1'b0;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ref_pick(input int dp,
                                  input logic [1:0] v,
                                  input int lst);
    if (v == 2'b11) return (dp != 0) ? 1 : 1 - lst;
    return v[1] ? 1 : 0;
  endfunction

  function automatic string tg(input string s, input int d);
    return $sformatf("%s[dp=%0d]", s, d);
  endfunction

  task automatic new_req(input int d, input int r);
    vld[d][r]  = 1'b1;
    rnw[d][r]  = 1'($urandom_range(0, 1));
    addr[d][r] = $urandom;
    wdat[d][r] = $urandom;
  endtask

  task automatic check_zero(input int d, input string s);
    check(tg({s, "_start"}, d), W'(ms[d]), '0);
    check(tg({s, "_busy"}, d), W'(bs[d]), '0);
    check(tg({s, "_done"}, d), W'({d1[d], d0[d]}), '0);
    check(tg({s, "_rdata"}, d), r0[d] | r1[d], '0);
    check(tg({s, "_grant"}, d), W'(gr[d]), '0);
    check(tg({s, "_maddr"}, d), ma[d], '0);
    check(tg({s, "_mwdata"}, d), mw[d], '0);
    check(tg({s, "_mrnw"}, d), W'(mrnw[d]), '0);
    check(tg({s, "_err"}, d), W'(er[d]), '0);
  endtask

  task automatic model_reset(input int d);
    infl[d]    = 1'b0;
    sdue[d]    = 1'b0;
    ddue[d]    = 2'b00;
    last[d]    = 1;
    mact[d]    = 1'b0;
    mcnt[d]    = 0;
    wn[d]      = 0;
    err_exp[d] = 1'b0;
    md[d]      = 1'b0;
    mrd[d]     = '0;
    vld[d]     = 2'b00;
    new_req(d, 0);
  endtask

  // one negedge: check cycle k outputs, then drive inputs for cycle k
  task automatic step(input int d);
    logic [1:0] ed;
    bit         idle_now;
    ed       = ddue[d];
    idle_now = !infl[d];
    check(tg("m_start", d), W'(ms[d]), W'(sdue[d]));
    check(tg("busy", d), W'(bs[d]), W'(infl[d]));
    check(tg("done0", d), W'(d0[d]), W'(ed[0]));
    check(tg("done1", d), W'(d1[d]), W'(ed[1]));
    check(tg("err", d), W'(er[d]), W'(err_exp[d]));
    if (ed != 2'b00)
      check(tg("rdata", d), ed[0] ? r0[d] : r1[d], exp_rd[d]);
    if (infl[d]) begin
      check(tg("grant", d), W'(gr[d]), W'(2'b01 << who[d]));
      check(tg("m_addr", d), ma[d], caddr[d]);
      check(tg("m_wdata", d), mw[d], cwd[d]);
      check(tg("m_rnw", d), W'(mrnw[d]), W'(crnw[d]));
    end else begin
      check(tg("grant_idle", d), W'(gr[d]), '0);
    end

    sdue[d] = 1'b0;
    ddue[d] = 2'b00;
    if (ed != 2'b00) begin
      infl[d] = 1'b0;
      last[d] = who[d];
      vld[d][who[d]] = 1'b0;
    end

    for (int r = 0; r < 2; r++) begin
      if (!vld[d][r]) begin
        if ($urandom_range(0, 99) < 60) new_req(d, r);
      end else if (!idle_now && who[d] == r) begin
        addr[d][r] = $urandom;
        wdat[d][r] = $urandom;
        rnw[d][r]  = ~rnw[d][r];
      end
    end

    if (idle_now && vld[d] != 2'b00) begin
      who[d]   = ref_pick(d, vld[d], last[d]);
      crnw[d]  = rnw[d][who[d]];
      caddr[d] = addr[d][who[d]];
      cwd[d]   = wdat[d][who[d]];
      infl[d]  = 1'b1;
      sdue[d]  = 1'b1;
    end

    md[d] = 1'b0;
    if (ms[d]) begin
      mact[d] = 1'b1;
      mcnt[d] = int'($urandom_range(0, 3));
      wn[d]   = 0;
      md[d]   = 1'($urandom_range(0, 1));
      mrd[d]  = $urandom;
    end else if (mact[d]) begin
      wn[d]++;
      if (!hold && mcnt[d] == 0) begin
        md[d]     = 1'b1;
        mrd[d]    = $urandom;
        exp_rd[d] = mrd[d];
        ddue[d]   = 2'b01 << who[d];
        mact[d]   = 1'b0;
      end else begin
        if (mcnt[d] > 0) mcnt[d]--;
`ifdef ARB_TIMEOUT_EN
        if (wn[d] == TO) begin
          exp_rd[d]  = 32'hDEAD_BEEF;
          ddue[d]    = 2'b01 << who[d];
          err_exp[d] = 1'b1;
          mact[d]    = 1'b0;
        end
`endif
      end
    end else begin
      md[d]  = 1'($urandom_range(0, 1));
      mrd[d] = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step(0);
      step(1);
    end
  endtask

  task automatic apply_release;
    @(negedge clk);
    model_reset(0);
    model_reset(1);
    rst_n = 1'b1;
    step(0);
    step(1);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      vld[d] = 2'b00;
    end

    repeat (3) @(negedge clk);
    check_zero(0, "rst");
    check_zero(1, "rst");
    apply_release();
    run(400);

    hold = 1'b1;
    n = 0;
    while (!(mact[0] && mact[1] && wn[0] >= 2 && wn[1] >= 2) && n < 80) begin
      @(negedge clk);
      step(0);
      step(1);
      n++;
    end
    check("wait_reached", W'(n < 80), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check_zero(0, "abort");
    check_zero(1, "abort");
    hold = 1'b0;
    apply_release();
    run(300);

`ifdef ARB_TIMEOUT_EN
    hold = 1'b1;
    run(60);
    check("err_sticky0", W'(er[0]), W'(1));
    check("err_sticky1", W'(er[1]), W'(1));
    hold = 1'b0;
    run(40);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_master_arbiter.md
Name: avalon_master_arbiter

Overview:
- Shares one avalon_mm_master command interface (start/rnw/address/data_to_write in; done/data_read out) between two RISC-V requesters: requester 0 = instruction fetch, requester 1 = data load/store.
- Sits between the core/interconnect logic and a single Avalon-MM master, so fetch and data traffic use one bus port.
- Serialises transactions with round-robin or fixed data-priority arbitration, one outstanding transaction at a time.

Parameters:
- WIDTH, 32, address and data width in bits.
- DATA_PRIORITY, 0: 0 = round-robin; 1 = requester 1 always wins ties.
- TIMEOUT, 255: cycle limit in WAIT; used only with ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- req0_valid  in  1  fetch request, level, held until req0_done
- req0_rnw  in  1  1 = read, 0 = write
- req0_addr  in  WIDTH  fetch address
- req0_wdata  in  WIDTH  write data
- req0_done  out  1  one-cycle completion pulse
- req0_rdata  out  WIDTH  read data, valid while req0_done = 1
- req1_valid, req1_rnw, req1_addr, req1_wdata, req1_done, req1_rdata  (same as requester 0)  data requester
- m_start  out  1  one-cycle start to master
- m_rnw  out  1  direction to master
- m_addr  out  WIDTH  address_to_access
- m_wdata  out  WIDTH  data_to_write
- m_done  in  1  master completion pulse
- m_rdata  in  WIDTH  master data_read
- grant  out  2  one-hot owner of the bus, for debug
- busy  out  1  high in any state except IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Clock/reset: one clock CLK; asynchronous active-low reset RST_N.
- Reset values: state = IDLE; all outputs 0; last_grant = 1, so fetch wins the first tie.
- State machine:
  - IDLE: if any valid, pick a winner, capture its rnw/addr/wdata into registers, set grant, go to ISSUE.
  - ISSUE: m_start = 1 for exactly one cycle; go to WAIT.
  - WAIT: hold m_rnw/m_addr/m_wdata stable. On m_done, capture m_rdata and go to RESP.
  - RESP: assert reqX_done = 1 and reqX_rdata = captured data for the grantee only; update last_grant; go to IDLE.
- Master outputs: m_rnw/m_addr/m_wdata come from the capture registers and are held from ISSUE through RESP.
- Arbitration, DATA_PRIORITY = 0: if both valid, grant the requester not equal to last_grant; if only one is valid, grant it.
- Arbitration, DATA_PRIORITY = 1: requester 1 wins whenever req1_valid = 1.
- Latency: valid sampled in IDLE at cycle N → m_start at N+1. m_done at cycle M → reqX_done at M+1. Minimum turnaround is 4 cycles for a 1-cycle master.
- Back-to-back: a requester may present its next request in its done cycle. It is sampled in the following IDLE cycle; no bubble beyond IDLE.
- Request inputs are ignored outside IDLE. Requester changes after capture have no effect.
- m_done outside WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE with outputs 0; no done is issued for the aborted transaction.
- Width rule: no arithmetic on the datapath; data and addresses pass through unchanged.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each WAIT cycle.
  - When it reaches TIMEOUT without m_done: go to RESP with rdata = ARB_ERR_DATA (32'hDEAD_BEEF) and set err (sticky until reset).
  - A late m_done is then ignored.
- Not defined: WAIT holds indefinitely; err is tied 0; no counter logic exists.

Decomposition:
- Shared package arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - REQ_INSTR = 0, REQ_EXT = 1
  - ARB_ERR_DATA
  - default TIMEOUT constant
- One combinational sub-module, arb_rr_pick: inputs valid[1:0], last_grant, DATA_PRIORITY; output one-hot winner. Reusable if a debug requester is added later.

Test Plan:
- Single fetch: req0_valid = 1, addr 0x100, master returns 0x00000013 after 2 wait cycles → m_start one cycle after valid; req0_done pulses once with rdata 0x00000013; req1_done stays 0.
- Simultaneous requests, round-robin from reset: both valid, req0 addr 0x200, req1 write addr 0x8000 data 0xA5A5A5A5 → fetch served first, then data write (m_rnw = 0, m_wdata = 0xA5A5A5A5); alternation continues over 6 transactions.
- DATA_PRIORITY = 1, both held continuously → all grants go to requester 1 while it is valid; req0 is served only when req1_valid = 0.
- Back-to-back on requester 1: new addr presented in the done cycle → next m_start exactly 2 cycles after the done pulse with the new address.
- RST_N asserted during WAIT → all outputs 0 within the same cycle, no done pulse; after release, a fresh req0 completes normally.
- ARB_TIMEOUT_EN, TIMEOUT = 8, m_done never asserted → req0_done at cycle 8 of WAIT with rdata 0xDEADBEEF; err = 1 and stays set; a later m_done produces no pulse.
